pattern_ddr_writer: RTL and testbench

- Writes one binary (1 bit/pixel) pattern into DDR3 through the EMIF Avalon-MM port, in the layout the HDMI pattern fetch path consumes.
- Layout is a 256-bit header word at the base address, followed by body words holding 256 pixels each.
- Pixel bits arrive from the host-side loader as a 32-bit valid/ready stream, are packed into 256-bit words and written one word per transaction.

---
 rtl/pattern_ddr_writer.sv | 197 +++++++++++++++++++
 tb/tb_pattern_ddr_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_ddr_writer.sv
// Packs a 1-bit/pixel stream into 256-bit words and writes header + body words to DDR through the EMIF port.
// Build option PAT_WR_CHECKSUM_EN: body words first, header last at base with an XOR checksum in its rsv field.
module pattern_ddr_writer #(
  parameter int ADDR_W = 22,
  parameter int PIX_W  = 12
) (
  input  logic              ddr_emif_clk,
  input  logic              ddr_emif_rst_n,
  input  logic              pat_wr_start,
  input  logic [PIX_W-1:0]  pat_h_pix,
  input  logic [PIX_W-1:0]  pat_v_pix,
  input  logic [31:0]       pat_num,
  input  logic [ADDR_W-1:0] pat_base_addr,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              ddr_emif_ready,
  output logic              ddr_emif_write,
  output logic              ddr_emif_read,
  output logic [ADDR_W-1:0] ddr_emif_addr,
  output logic [255:0]      ddr_emif_write_data,
  output logic [31:0]       ddr_emif_byte_enable,
  output logic [4:0]        ddr_emif_burst_count,
  output logic              pat_wr_busy,
  output logic              pat_wr_done,
  output logic              pat_wr_err
);

  // Handshakes: a stream beat moves on a rising edge with s_valid && s_ready; an EMIF write
  // holds addr/data stable from assertion until the edge of a cycle with ddr_emif_ready high.
  typedef enum logic [2:0] {IDLE, WR_HEAD, COLLECT, WR_BODY, DONE} state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    h_q, v_q;
  logic [31:0]         num_q;
  logic [ADDR_W-1:0]   base_q, body_addr_q, end_addr;
  logic [23:0]         total_q, start_total;
  logic [16:0]         words_q, words_left_q, start_words;
  logic [19:0]         beats_left_q, start_beats;
  logic [2:0]          lane_q;
  logic [255:0]        word_q, header_word;
  logic [31:0]         tail_mask, beat_data, rsv;
  logic                err_q, start_ok, beat, last_beat, body_accept;

  assign start_total = 24'(pat_h_pix) * 24'(pat_v_pix);
  assign start_words = {1'b0, start_total[23:8]} + {16'd0, |start_total[7:0]};
  assign start_beats = {1'b0, start_total[23:5]} + {19'd0, |start_total[4:0]};

  assign start_ok    = pat_wr_start && (state_q == IDLE);
  assign beat        = s_valid && (state_q == COLLECT);
  assign last_beat   = (beats_left_q == 20'd1);
  assign body_accept = (state_q == WR_BODY) && ddr_emif_ready;

  // Pixels past the pattern end in the final beat are cleared.
  assign tail_mask = (total_q[4:0] == 5'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> total_q[4:0]);
  assign beat_data = last_beat ? (s_data & tail_mask) : s_data;

`ifdef PAT_WR_CHECKSUM_EN
  logic [31:0] csum_q;

  function automatic logic [31:0] xor_lanes(input logic [255:0] w);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ w[i*32 +: 32];
    return acc;
  endfunction

  assign rsv = csum_q;
`else
  assign rsv = 32'd0;
`endif

  assign end_addr    = base_q + ADDR_W'(words_q);
  assign header_word = {32'(h_q), 32'(v_q), {8'd0, total_q}, num_q, {15'd0, words_q},
                        32'(base_q), 32'(end_addr), rsv};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pat_wr_start) begin
`ifdef PAT_WR_CHECKSUM_EN
          state_d = (start_words == 17'd0) ? WR_HEAD : COLLECT;
`else
          state_d = WR_HEAD;
`endif
        end
      end
      WR_HEAD: begin
        if (ddr_emif_ready) begin
`ifdef PAT_WR_CHECKSUM_EN
          state_d = DONE;
`else
          state_d = (words_q == 17'd0) ? DONE : COLLECT;
`endif
        end
      end
      COLLECT: begin
        if (beat && (lane_q == 3'd7 || last_beat)) state_d = WR_BODY;
      end
      WR_BODY: begin
        if (ddr_emif_ready) begin
          if (words_left_q == 17'd1) begin
`ifdef PAT_WR_CHECKSUM_EN
            state_d = WR_HEAD;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = COLLECT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) begin
      state_q      <= IDLE;
      h_q          <= '0;
      v_q          <= '0;
      num_q        <= '0;
      base_q       <= '0;
      total_q      <= '0;
      words_q      <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      body_addr_q  <= '0;
      err_q        <= 1'b0;
`ifdef PAT_WR_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      // Any start outside IDLE (including the DONE cycle) is dropped and flagged.
      err_q   <= pat_wr_start && (state_q != IDLE);
      if (start_ok) begin
        h_q          <= pat_h_pix;
        v_q          <= pat_v_pix;
        num_q        <= pat_num;
        base_q       <= pat_base_addr;
        total_q      <= start_total;
        words_q      <= start_words;
        words_left_q <= start_words;
        beats_left_q <= start_beats;
        lane_q       <= '0;
        word_q       <= '0;
        body_addr_q  <= pat_base_addr + ADDR_W'(1);
`ifdef PAT_WR_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end
      if (beat) begin
        word_q[{~lane_q, 5'd0} +: 32] <= beat_data;
        lane_q       <= lane_q + 3'd1;
        beats_left_q <= beats_left_q - 20'd1;
      end
      if (body_accept) begin
        word_q       <= '0;
        lane_q       <= '0;
        words_left_q <= words_left_q - 17'd1;
        body_addr_q  <= body_addr_q + ADDR_W'(1);
`ifdef PAT_WR_CHECKSUM_EN
        csum_q       <= csum_q ^ xor_lanes(word_q);
`endif
      end
    end
  end

  always_comb begin
    s_ready             = (state_q == COLLECT);
    ddr_emif_write      = 1'b0;
    ddr_emif_addr       = '0;
    ddr_emif_write_data = '0;
    if (state_q == WR_HEAD) begin
      ddr_emif_write      = 1'b1;
      ddr_emif_addr       = base_q;
      ddr_emif_write_data = header_word;
    end else if (state_q == WR_BODY) begin
      ddr_emif_write      = 1'b1;
      ddr_emif_addr       = body_addr_q;
      ddr_emif_write_data = word_q;
    end
  end

  assign ddr_emif_read        = 1'b0;
  assign ddr_emif_byte_enable = 32'hFFFF_FFFF;
  assign ddr_emif_burst_count = 5'd1;
  assign pat_wr_busy          = (state_q == WR_HEAD) || (state_q == COLLECT) || (state_q == WR_BODY);
  assign pat_wr_done          = (state_q == DONE);
  assign pat_wr_err           = err_q;

endmodule

// File: tb/tb_pattern_ddr_writer.sv
// Bench for pattern_ddr_writer: a pixel-level reference model predicts every EMIF write (address + data),
// with random stream gaps and EMIF stalls plus directed boundary cases.
module tb_pattern_ddr_writer;
  localparam int ADDR_W = 22;
  localparam int PIX_W  = 12;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pat_wr_start = 1'b0;
  logic [PIX_W-1:0]  pat_h_pix = '0;
  logic [PIX_W-1:0]  pat_v_pix = '0;
  logic [31:0]       pat_num = '0;
  logic [ADDR_W-1:0] pat_base_addr = '0;
  logic [31:0]       s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              ddr_emif_ready = 1'b1;
  logic              ddr_emif_write, ddr_emif_read;
  logic [ADDR_W-1:0] ddr_emif_addr;
  logic [255:0]      ddr_emif_write_data;
  logic [31:0]       ddr_emif_byte_enable;
  logic [4:0]        ddr_emif_burst_count;
  logic              pat_wr_busy, pat_wr_done, pat_wr_err;

  pattern_ddr_writer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .ddr_emif_clk(clk), .ddr_emif_rst_n(rst_n),
    .pat_wr_start(pat_wr_start), .pat_h_pix(pat_h_pix), .pat_v_pix(pat_v_pix),
    .pat_num(pat_num), .pat_base_addr(pat_base_addr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ddr_emif_ready(ddr_emif_ready), .ddr_emif_write(ddr_emif_write), .ddr_emif_read(ddr_emif_read),
    .ddr_emif_addr(ddr_emif_addr), .ddr_emif_write_data(ddr_emif_write_data),
    .ddr_emif_byte_enable(ddr_emif_byte_enable), .ddr_emif_burst_count(ddr_emif_burst_count),
    .pat_wr_busy(pat_wr_busy), .pat_wr_done(pat_wr_done), .pat_wr_err(pat_wr_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0, fails = 0;
  int acc_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [ADDR_W-1:0] exp_a_q[$];
  logic [255:0]      exp_d_q[$];
  logic [31:0]       beat_q[$];

  logic              hs_seen = 1'b0, acc_seen = 1'b0, pend = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [255:0]      pdata = '0;

  bit rand_gaps = 1'b1, rand_ready = 1'b0, force_low = 1'b0;
  int stall_n = 0, wr_wait = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xor_lanes(input logic [255:0] w);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ w[i*32 +: 32];
    return acc;
  endfunction

  // ---------------- stream driver ----------------
  always @(posedge clk) begin
    #1;
    if (hs_seen && beat_q.size() > 0) beat_q.delete(0);
    if (beat_q.size() == 0) s_valid = 1'b0;
    else if (!s_valid || hs_seen) begin
      s_valid = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = beat_q[0];
    end
  end

  // ---------------- EMIF ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (acc_seen || !rst_n) wr_wait = 0;
    if (force_low) ddr_emif_ready = 1'b0;
    else if (ddr_emif_write && wr_wait < stall_n) begin
      ddr_emif_ready = 1'b0;
      wr_wait++;
    end else ddr_emif_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_seen = 1'b0; acc_seen = 1'b0; pend = 1'b0;
    end else begin
      hs_seen  = s_valid && s_ready;
      acc_seen = ddr_emif_write && ddr_emif_ready;
      if (pend) begin
        chk("hold_write", 256'(ddr_emif_write), 256'(1));
        chk("hold_addr", 256'(ddr_emif_addr), 256'(paddr));
        chk("hold_data", ddr_emif_write_data, pdata);
      end
      if (ddr_emif_write) chk("sready_low_while_writing", 256'(s_ready), 256'(0));
      if (acc_seen) begin
        acc_cnt++;
        chk("write_expected", 256'(exp_a_q.size() != 0), 256'(1));
        if (exp_a_q.size() != 0) begin
          chk("wr_addr", 256'(ddr_emif_addr), 256'(exp_a_q.pop_front()));
          chk("wr_data", ddr_emif_write_data, exp_d_q.pop_front());
        end
      end
      if (pat_wr_done) begin
        done_cnt++;
        chk("busy_low_at_done", 256'(pat_wr_busy), 256'(0));
      end
      if (pat_wr_err) err_cnt++;
      pend  = ddr_emif_write && !ddr_emif_ready;
      paddr = ddr_emif_addr;
      pdata = ddr_emif_write_data;
    end
  end

  // ---------------- reference model + start ----------------
  // Builds the pixel list, lays it into 256-pixel words, and queues the expected writes.
  task automatic start_pat(input int h, input int v, input logic [31:0] num, input int base,
                           input bit const_fill, input logic [31:0] fill, output int nwr);
    int total, words, nb, p;
    logic [31:0] lb[$];
    logic [31:0] tmp, csum;
    logic [255:0] w, hdr;
    total = h * v;
    words = (total + 255) / 256;
    nb    = (total + 31) / 32;
    for (int i = 0; i < nb; i++) lb.push_back(const_fill ? fill : $urandom());
    csum = '0;
    hdr  = {h, v, total, num, words, base, (base + words) & AMASK, 32'd0};
`ifndef PAT_WR_CHECKSUM_EN
    exp_a_q.push_back(ADDR_W'(base)); exp_d_q.push_back(hdr);
`endif
    for (int k = 0; k < words; k++) begin
      w = '0;
      for (int j = 0; j < 256; j++) begin
        p = k * 256 + j;
        if (p < total) begin
          tmp = lb[p / 32];
          w[255 - j] = tmp[31 - (p % 32)];
        end
      end
      exp_a_q.push_back(ADDR_W'((base + 1 + k) & AMASK)); exp_d_q.push_back(w);
      csum = csum ^ xor_lanes(w);
    end
`ifdef PAT_WR_CHECKSUM_EN
    hdr[31:0] = csum;
    exp_a_q.push_back(ADDR_W'(base)); exp_d_q.push_back(hdr);
`endif
    nwr = words + 1;
    for (int i = 0; i < nb; i++) beat_q.push_back(lb[i]);
    @(posedge clk); #1;
    pat_h_pix = PIX_W'(h); pat_v_pix = PIX_W'(v); pat_num = num; pat_base_addr = ADDR_W'(base);
    pat_wr_start = 1'b1;
    @(posedge clk); #1;
    pat_wr_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int a0, input int nwr);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 256'(done_cnt - d0), 256'(1));
    chk({tag, "_accepts"}, 256'(acc_cnt - a0), 256'(nwr));
    chk({tag, "_exp_left"}, 256'(exp_a_q.size()), 256'(0));
    chk({tag, "_beats_left"}, 256'(beat_q.size()), 256'(0));
    chk({tag, "_busy_idle"}, 256'(pat_wr_busy), 256'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, a0, e0, nwr, n, dummy;
    logic [255:0] ones100;

    #3;
    chk("rst_write", 256'(ddr_emif_write), 256'(0));
    chk("rst_read", 256'(ddr_emif_read), 256'(0));
    chk("rst_addr", 256'(ddr_emif_addr), 256'(0));
    chk("rst_data", ddr_emif_write_data, 256'(0));
    chk("rst_be", 256'(ddr_emif_byte_enable), 256'(32'hFFFF_FFFF));
    chk("rst_burst", 256'(ddr_emif_burst_count), 256'(1));
    chk("rst_busy_done_err", 256'({pat_wr_busy, pat_wr_done, pat_wr_err}), 256'(0));
    chk("rst_sready", 256'(s_ready), 256'(0));
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 16x16, ready always high
    d0 = done_cnt; a0 = acc_cnt;
    start_pat(16, 16, 32'h0000_0007, 32'h100, 1'b1, 32'hA5A5_A5A5, nwr);
    chk("t1_nwr", 256'(nwr), 256'(2));
    wait_done("t1", d0, a0, nwr);

    // 10x10 all ones: body must be exactly 100 leading ones
    ones100 = '0;
    for (int i = 0; i < 100; i++) ones100[255 - i] = 1'b1;
    d0 = done_cnt; a0 = acc_cnt;
    start_pat(10, 10, 32'h1234_5678, 0, 1'b1, 32'hFFFF_FFFF, nwr);
    chk("t2_body_model", exp_d_q[exp_d_q.size() - 1], ones100);
    wait_done("t2", d0, a0, nwr);

    // 16x16 with 5-cycle stall on each write
    stall_n = 5;
    d0 = done_cnt; a0 = acc_cnt;
    start_pat(16, 16, 32'h0000_0009, 32'h100, 1'b1, 32'hA5A5_A5A5, nwr);
    wait_done("t3_stall", d0, a0, nwr);
    stall_n = 0;

    // start pulsed mid-transfer
    rand_ready = 1'b1;
    d0 = done_cnt; a0 = acc_cnt; e0 = err_cnt;
    start_pat(40, 30, 32'hCAFE_0001, 32'h2000, 1'b0, 32'h0, nwr);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 5000) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    pat_h_pix = PIX_W'(5); pat_v_pix = PIX_W'(5); pat_num = 32'hDEAD; pat_base_addr = ADDR_W'(32'h55);
    pat_wr_start = 1'b1;
    @(posedge clk); #1;
    pat_wr_start = 1'b0;
    wait_done("t4_err", d0, a0, nwr);
    chk("t4_err_pulses", 256'(err_cnt - e0), 256'(1));
    rand_ready = 1'b0;

    // zero-size pattern: header only
    d0 = done_cnt; a0 = acc_cnt;
    start_pat(0, 20, 32'h0000_00AA, 32'h3000, 1'b0, 32'h0, nwr);
    chk("t5_nwr", 256'(nwr), 256'(1));
    wait_done("t5_empty", d0, a0, nwr);

    // async reset during a body write
    d0 = done_cnt; a0 = acc_cnt; e0 = err_cnt;
    start_pat(16, 16, 32'h0000_0011, 32'h400, 1'b0, 32'h0, dummy);
    n = 0;
    while (acc_cnt == a0 && n < 2000) begin @(posedge clk); n++; end
    force_low = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ddr_emif_write && n < 2000);
    chk("t6_body_pending", 256'(ddr_emif_write), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_write_drop", 256'(ddr_emif_write), 256'(0));
    chk("t6_async_busy_drop", 256'(pat_wr_busy), 256'(0));
    exp_a_q.delete(); exp_d_q.delete(); beat_q.delete();
    force_low = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_done", 256'(done_cnt - d0), 256'(0));
    chk("t6_no_err", 256'(err_cnt - e0), 256'(0));
    d0 = done_cnt; a0 = acc_cnt;
    start_pat(16, 16, 32'h0000_0012, 32'h400, 1'b0, 32'h0, nwr);
    wait_done("t6_restart", d0, a0, nwr);

    // random sizes, random backpressure, one base at the top of the address space
    rand_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      int h, v, base;
      h = $urandom_range(0, 48);
      v = $urandom_range(1, 48);
      base = (r == 0) ? AMASK - 1 : int'($urandom_range(0, AMASK));
      d0 = done_cnt; a0 = acc_cnt;
      start_pat(h, v, $urandom(), base, 1'b0, 32'h0, nwr);
      wait_done($sformatf("rnd%0d", r), d0, a0, nwr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
